// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the pipeline control and the multiply/divide unit
// master drives start, funct3, rs1, rs2 and flush; slave returns busy, done and result.
interface muldiv_if #(parameter int N = 32);
    logic         start;
    logic [2:0]   funct3;
    logic [N-1:0] rs1;
    logic [N-1:0] rs2;
    logic         flush;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    modport master(output start, funct3, rs1, rs2, flush, input busy, done, result);
    modport slave(input start, funct3, rs1, rs2, flush, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
// Ports: clk, rst_n (async active-low), bus (muldiv_if.slave):
//   start/funct3/rs1/rs2/flush in; busy, done (1-cycle pulse), result (registered) out.
// Optional: define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path.
module muldiv_unit #(parameter int N = 32) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t        state;
    logic [CW-1:0] count;
    logic [2:0]    op;
    logic [N-1:0]  a;       // multiplicand magnitude, or divisor magnitude
    logic [2*N-1:0] acc;    // {product high, product low/multiplier}, or quotient/dividend in low half
    logic [N:0]    rem;
    logic          neg_q, neg_r, busy, done;
    logic [N-1:0]  result;
    logic          is_div, s1, s2, sg1, sg2, div0, ovf, fast;
    logic [N-1:0]  mag1, mag2, quo, rmd, fix_val;
    logic [2*N-1:0] prod, fast_acc;
    logic [N:0]    msum, trial, diff;
    assign is_div = bus.funct3[2];
    // MULHSU treats rs2 as unsigned, MULHU/DIVU/REMU treat both as unsigned
    assign s1   = is_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    assign s2   = is_div ? ~bus.funct3[0] : ~bus.funct3[1];
    assign sg1  = s1 & bus.rs1[N-1];
    assign sg2  = s2 & bus.rs2[N-1];
    assign mag1 = sg1 ? -bus.rs1 : bus.rs1;
    assign mag2 = sg2 ? -bus.rs2 : bus.rs2;
    assign div0 = is_div && (bus.rs2 == '0);
    assign ovf  = is_div && !bus.funct3[0] && (bus.rs1 == {1'b1, {(N-1){1'b0}}}) && (&bus.rs2);
`ifdef MULDIV_FAST_MUL_EN
    logic signed [N:0]     fx1, fx2;
    logic signed [2*N+1:0] fprod;
    assign fx1      = {sg1, bus.rs1};
    assign fx2      = {sg2, bus.rs2};
    assign fprod    = fx1 * fx2;
    assign fast     = !is_div;
    assign fast_acc = fprod[2*N-1:0];
`else
    assign fast     = 1'b0;
    assign fast_acc = '0;
`endif
    // multiply step: conditionally add multiplicand to the high half, then shift right
    assign msum  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, a} : '0);
    // divide step: shift next dividend bit into the partial remainder and trial-subtract
    assign trial = {rem[N-1:0], acc[N-1]};
    assign diff  = trial - {1'b0, a};
    assign prod    = neg_q ? -acc : acc;
    assign quo     = neg_q ? -acc[N-1:0] : acc[N-1:0];
    assign rmd     = neg_r ? -rem[N-1:0] : rem[N-1:0];
    assign fix_val = !op[2] ? ((op[1:0] == 2'b00) ? prod[N-1:0] : prod[2*N-1:N])
                            : (op[1] ? rmd : quo);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            op     <= '0;
            a      <= '0;
            acc    <= '0;
            rem    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            if (bus.flush) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (bus.start) begin
                        op    <= bus.funct3;
                        count <= '0;
                        busy  <= 1'b1;
                        // special cases preload the final quotient/remainder with no negation
                        if (div0) begin
                            acc   <= {{N{1'b0}}, {N{1'b1}}};
                            rem   <= {1'b0, bus.rs1};
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= FIX;
                        end else if (ovf) begin
                            acc   <= {{N{1'b0}}, bus.rs1};
                            rem   <= '0;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= FIX;
                        end else if (fast) begin
                            acc   <= fast_acc;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= FIX;
                        end else begin
                            a     <= is_div ? mag2 : mag1;
                            acc   <= {{N{1'b0}}, is_div ? mag1 : mag2};
                            rem   <= '0;
                            neg_q <= sg1 ^ sg2;
                            neg_r <= sg1;
                            state <= CALC;
                        end
                    end
                    CALC: begin
                        if (!op[2]) acc <= {msum, acc[N-1:1]};
                        else begin
                            rem          <= diff[N] ? trial : diff;
                            acc[N-1:0]   <= {acc[N-2:0], ~diff[N]};
                        end
                        count <= count + 1'b1;
                        if (count == CW'(N-1)) state <= FIX;
                    end
                    FIX: begin
                        result <= fix_val;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed self-checking bench for muldiv_unit against a behavioural model
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [31:0] last_exp = '0;
    always #5 clk = ~clk;
    muldiv_if #(.N(32)) bus();
    muldiv_unit #(.N(32)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] model(logic [2:0] f, logic [31:0] x, logic [31:0] y);
        logic signed [63:0] sx, sy, zx, zy, p;
        int ix, iy;
        logic ov;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        zx = {32'b0, x};
        zy = {32'b0, y};
        ix = x;
        iy = y;
        ov = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * zy; return p[63:32]; end
            3'd3: begin p = zx * zy; return p[63:32]; end
            3'd4: return (y == 0) ? 32'hFFFF_FFFF : ov ? x : 32'(ix / iy);
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: return (y == 0) ? x : ov ? 32'd0 : 32'(ix % iy);
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction
    function automatic int latency(logic [2:0] f, logic [31:0] x, logic [31:0] y);
        if (f[2]) return ((y == 0) || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) ? 2 : 34;
`ifdef MULDIV_FAST_MUL_EN
        return 2;
`else
        return 34;
`endif
    endfunction
    // called one time unit after a rising edge; drives a start in that cycle (cycle 0)
    task automatic run(string tag, logic [2:0] f, logic [31:0] x, logic [31:0] y);
        int cyc, bc, lat;
        logic [31:0] exp;
        exp = model(f, x, y);
        lat = latency(f, x, y);
        bus.funct3 = f;
        bus.rs1 = x;
        bus.rs2 = y;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        bc = 0;
        while (!bus.done && cyc < 40) begin
            if (bus.busy) bc++;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".lat"}, 64'(cyc), 64'(lat));
        check({tag, ".busy_cycles"}, 64'(bc), 64'(lat - 1));
        check({tag, ".busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, ".result"}, 64'(bus.result), 64'(exp));
        last_exp = exp;
        @(posedge clk); #1;
        check({tag, ".done_one_cycle"}, 64'(bus.done), 64'd0);
    endtask
    function automatic logic [31:0] pick();
        case ($urandom_range(9, 0))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(20, 0));
            default: return $urandom;
        endcase
    endfunction
    initial begin
        int cyc, dn;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.funct3 = '0;
        bus.rs1 = '0;
        bus.rs2 = '0;
        #1 rst_n = 1'b0;
        #1;
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.done", 64'(bus.done), 64'd0);
        check("reset.result", 64'(bus.result), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run("mul", 3'd0, 32'd7, 32'hFFFF_FFFD);
        run("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000);
        run("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run("div", 3'd4, 32'hFFFF_FFF9, 32'd2);
        run("rem", 3'd6, 32'hFFFF_FFF9, 32'd2);
        run("divu", 3'd5, 32'd100, 32'd7);
        run("remu", 3'd7, 32'd100, 32'd7);
        run("div0", 3'd4, 32'd5, 32'd0);
        run("remu0", 3'd7, 32'd5, 32'd0);
        run("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        for (int i = 0; i < 40; i++) run("rand", 3'($urandom_range(7, 0)), pick(), pick());
        // flush mid-divide: busy drops, no done, result keeps previous completion
        bus.funct3 = 3'd4;
        bus.rs1 = 32'd1000;
        bus.rs2 = 32'd3;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush.busy", 64'(bus.busy), 64'd0);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) dn++;
            @(posedge clk); #1;
        end
        check("flush.no_done", 64'(dn), 64'd0);
        check("flush.result", 64'(bus.result), 64'(last_exp));
        // start pulsed while busy is ignored
        bus.funct3 = 3'd5;
        bus.rs1 = 32'd100;
        bus.rs2 = 32'd7;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        dn = 0;
        while (!bus.done && cyc < 40) begin
            if (cyc == 5) begin
                bus.start = 1'b1;
                bus.funct3 = 3'd0;
                bus.rs1 = 32'd3;
                bus.rs2 = 32'd3;
            end else bus.start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        check("ignored_start.lat", 64'(cyc), 64'd34);
        check("ignored_start.result", 64'(bus.result), 64'd14);
        @(posedge clk); #1;
        check("ignored_start.idle", 64'(bus.busy), 64'd0);
        // async reset in cycle 12 of a DIVU
        bus.funct3 = 3'd5;
        bus.rs1 = 32'd1000;
        bus.rs2 = 32'd7;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (11) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid.busy", 64'(bus.busy), 64'd0);
        check("rst_mid.done", 64'(bus.done), 64'd0);
        check("rst_mid.result", 64'(bus.result), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run("mul_after_rst", 3'd0, 32'd7, 32'hFFFF_FFFD);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
